data_mem_responder: RTL

//  Responder end of the processor data-memory interface: accepts load/store

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_word_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned WAIT_CNT_W = 4;

  // Misaligned, or word index outside the window (addresses below base wrap large).
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channels between a load/store port and the memory responder.
interface data_mem_responder_if;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic [mem_pkg::BE_W-1:0] req_be;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word-organised RAM: synchronous byte-enabled write, asynchronous read, no reset.
module word_ram import mem_pkg::*; #(
  parameter int unsigned DepthWords = 256
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(DepthWords)-1:0] waddr_i,
  input  logic [31:0]                   wdata_i,
  input  logic [BE_W-1:0]               be_i,
  input  logic [$clog2(DepthWords)-1:0] raddr_i,
  output logic [31:0]                   rdata_o
);

  logic [31:0] mem_q [DepthWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: accepts one load/store, waits WaitCycles, commits and answers.
module data_mem_responder import mem_pkg::*; #(
  parameter int unsigned DepthWords = 256,
  parameter int unsigned WaitCycles = 2,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  bus,
  output logic                 busy_o
);

  localparam int unsigned IdxW = $clog2(DepthWords);
  localparam logic [WAIT_CNT_W-1:0] WaitInit =
      (WaitCycles == 0) ? '0 : WAIT_CNT_W'(WaitCycles - 1);

  mem_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  commit;
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [BE_W-1:0]       cur_be;
  logic                  cur_err;
  logic [IdxW-1:0]       cur_idx;
  logic [31:0]           ram_rdata;

  // With zero wait states the commit happens on the accept edge, straight from the bus.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = bus.req_write;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_err = addr_err(cur_addr, BaseAddr, DepthWords);
    cur_idx = IdxW'((cur_addr - BaseAddr) >> 2);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (WaitCycles == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = cur_err;
      rdata_d = (cur_write || cur_err) ? 32'h0 : ram_rdata;
    end
  end

  word_ram #(
    .DepthWords (DepthWords)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (commit && cur_write && !cur_err),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .raddr_i (cur_idx),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy_o        = (state_q != IDLE);

endmodule
